// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves MIPS conditional branches (beq, bne, blez, bgtz, bltz, bgez,
// bltzal, bgezal) and registers the outcome. It holds a PC-indexed table of
// 2-bit saturating counters: the table serves IF-stage predictions and is
// trained on every accepted resolution. It also keeps saturating counters
// of resolved branches and of mispredictions.
//
// Ports
//   clk            system clock, rising edge
//   resetn         synchronous reset, active low (dominates everything)
//   stall          freeze: outputs, table and counters hold
//   pred_pc        IF-stage fetch PC
//   pred_taken     combinational prediction (counter MSB at pred_pc index)
//   res_valid      resolution request this cycle
//   res_op/res_rt  opcode and rt field (REGIMM subcode)
//   res_a/res_b    forwarded rs / rt operands
//   res_pc         PC of the branch being resolved
//   res_pred       prediction that was used for this branch
//   out_valid      registered: a branch was accepted on the last active edge
//   out_taken      registered branch condition
//   out_link       registered: bgezal/bltzal
//   out_mispredict registered: out_taken != res_pred
//   branch_cnt     resolved branches, saturating
//   mispred_cnt    mispredictions, saturating
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [5:0]        res_op,
  input  logic [4:0]        res_rt,
  input  logic [DATA_W-1:0] res_a,
  input  logic [DATA_W-1:0] res_b,
  input  logic [PC_W-1:0]   res_pc,
  input  logic              res_pred,
  output logic              out_valid,
  output logic              out_taken,
  output logic              out_link,
  output logic              out_mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_INIT = 2'b01;
  localparam logic [1:0] CTR_MAX  = 2'b11;
  localparam logic [1:0] CTR_MIN  = 2'b00;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // -------------------------------------------------------------------------
  // Decode and condition evaluation
  // -------------------------------------------------------------------------
  logic a_neg;
  logic a_zero;
  logic a_eq_b;
  logic is_branch;
  logic cond;
  logic link;
  logic accept;
  logic mispredict;

  assign a_neg  = res_a[DATA_W-1];
  assign a_zero = (res_a == '0);
  assign a_eq_b = (res_a == res_b);

  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    link      = 1'b0;
    unique case (res_op)
      OP_BEQ: begin
        is_branch = 1'b1;
        cond      = a_eq_b;
      end
      OP_BNE: begin
        is_branch = 1'b1;
        cond      = !a_eq_b;
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        cond      = a_neg | a_zero;
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        cond      = !a_neg & !a_zero;
      end
      OP_REGIMM: begin
        unique case (res_rt)
          RT_BLTZ: begin
            is_branch = 1'b1;
            cond      = a_neg;
          end
          RT_BGEZ: begin
            is_branch = 1'b1;
            cond      = !a_neg;
          end
          RT_BLTZAL: begin
            is_branch = 1'b1;
            cond      = a_neg;
            link      = 1'b1;
          end
          RT_BGEZAL: begin
            is_branch = 1'b1;
            cond      = !a_neg;
            link      = 1'b1;
          end
          default: begin
            is_branch = 1'b0;
          end
        endcase
      end
      default: begin
        is_branch = 1'b0;
      end
    endcase
  end

  assign accept     = res_valid & is_branch & !stall;
  assign mispredict = cond ^ res_pred;

  // -------------------------------------------------------------------------
  // Branch history table
  // -------------------------------------------------------------------------
  logic [1:0]       bht [DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign wr_idx   = res_pc[IDX_W+1:2];

  // Read port sees the pre-update value on a same-index collision; no bypass.
  assign pred_taken = bht[pred_idx][1];

  assign ctr_cur = bht[wr_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (cond) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != CTR_MIN) ctr_next = ctr_cur - 2'd1;
    end
  end

  // Word-offset and upper PC bits do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                            res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

  // -------------------------------------------------------------------------
  // State update
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht[i] <= CTR_INIT;
      end
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_link       <= 1'b0;
      out_mispredict <= 1'b0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else if (!stall) begin
      out_valid      <= accept;
      out_taken      <= accept & cond;
      out_link       <= accept & link;
      out_mispredict <= accept & mispredict;
      if (accept) begin
        bht[wr_idx] <= ctr_next;
        if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + CNT_ONE;
        if (mispredict && (mispred_cnt != CNT_MAX)) mispred_cnt <= mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        stall;
  logic [31:0] pred_pc;
  logic        res_valid;
  logic [5:0]  res_op;
  logic [4:0]  res_rt;
  logic [31:0] res_a;
  logic [31:0] res_b;
  logic [31:0] res_pc;
  logic        res_pred;

  // Instance 0: default widths. Instance 1: 16-bit data, 16-entry table,
  // 4-bit statistics counters; it sees the low half of the operands.
  logic        pt0, ov0, ot0, ol0, om0;
  logic [15:0] bc0, mc0;
  logic        pt1, ov1, ot1, ol1, om1;
  logic [3:0]  bc1, mc1;

  branch_resolve_unit u0 (
    .clk(clk), .resetn(resetn), .stall(stall),
    .pred_pc(pred_pc), .pred_taken(pt0),
    .res_valid(res_valid), .res_op(res_op), .res_rt(res_rt),
    .res_a(res_a), .res_b(res_b), .res_pc(res_pc), .res_pred(res_pred),
    .out_valid(ov0), .out_taken(ot0), .out_link(ol0), .out_mispredict(om0),
    .branch_cnt(bc0), .mispred_cnt(mc0)
  );

  branch_resolve_unit #(.DATA_W(16), .IDX_W(4), .PC_W(32), .CNT_W(4)) u1 (
    .clk(clk), .resetn(resetn), .stall(stall),
    .pred_pc(pred_pc), .pred_taken(pt1),
    .res_valid(res_valid), .res_op(res_op), .res_rt(res_rt),
    .res_a(res_a[15:0]), .res_b(res_b[15:0]), .res_pc(res_pc), .res_pred(res_pred),
    .out_valid(ov1), .out_taken(ot1), .out_link(ol1), .out_mispredict(om1),
    .branch_cnt(bc1), .mispred_cnt(mc1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: counters kept as integers 0..3, stats as integers.
  int m_bht [2][64];
  int m_bc  [2];
  int m_mc  [2];
  bit m_ov  [2];
  bit m_ot  [2];
  bit m_ol  [2];
  bit m_om  [2];
  int idxw  [2] = '{6, 4};
  int cmax  [2] = '{65535, 15};
  int dw    [2] = '{32, 16};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int k, input logic [31:0] pc);
    return int'((pc >> 2) & ((32'd1 << idxw[k]) - 1));
  endfunction

  // Branch semantics on signed integers of width w.
  function automatic void ref_decode(input logic [5:0] op, input logic [4:0] rt,
                                     input longint a, input longint b, input int w,
                                     output bit isb, output bit tk, output bit lk);
    longint sa;
    sa  = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
    isb = 1'b0; tk = 1'b0; lk = 1'b0;
    case (op)
      6'd4: begin isb = 1; tk = (a == b); end
      6'd5: begin isb = 1; tk = (a != b); end
      6'd6: begin isb = 1; tk = (sa <= 0); end
      6'd7: begin isb = 1; tk = (sa > 0); end
      6'd1: begin
        case (rt)
          5'd0:  begin isb = 1; tk = (sa < 0); end
          5'd1:  begin isb = 1; tk = (sa >= 0); end
          5'd16: begin isb = 1; tk = (sa < 0);  lk = 1; end
          5'd17: begin isb = 1; tk = (sa >= 0); lk = 1; end
          default: isb = 0;
        endcase
      end
      default: isb = 0;
    endcase
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      longint mask, a, b;
      bit isb, tk, lk;
      int ix;
      mask = (longint'(1) << dw[k]) - 1;
      a = longint'(res_a) & mask;
      b = longint'(res_b) & mask;
      if (!resetn) begin
        for (int i = 0; i < 64; i++) m_bht[k][i] = 1;
        m_bc[k] = 0; m_mc[k] = 0;
        m_ov[k] = 0; m_ot[k] = 0; m_ol[k] = 0; m_om[k] = 0;
      end else if (!stall) begin
        ref_decode(res_op, res_rt, a, b, dw[k], isb, tk, lk);
        if (res_valid && isb) begin
          m_ov[k] = 1; m_ot[k] = tk; m_ol[k] = lk; m_om[k] = (tk != res_pred);
          ix = idx_of(k, res_pc);
          if (tk) m_bht[k][ix] = (m_bht[k][ix] == 3) ? 3 : m_bht[k][ix] + 1;
          else    m_bht[k][ix] = (m_bht[k][ix] == 0) ? 0 : m_bht[k][ix] - 1;
          if (m_bc[k] < cmax[k]) m_bc[k]++;
          if (m_om[k] && m_mc[k] < cmax[k]) m_mc[k]++;
        end else begin
          m_ov[k] = 0; m_ot[k] = 0; m_ol[k] = 0; m_om[k] = 0;
        end
      end
    end
  endtask

  // One clock: prediction checked before the edge, registered outputs after.
  task automatic step();
    #1;
    chk("pred_taken0", {31'd0, pt0}, {31'd0, m_bht[0][idx_of(0, pred_pc)] >= 2});
    chk("pred_taken1", {31'd0, pt1}, {31'd0, m_bht[1][idx_of(1, pred_pc)] >= 2});
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid0",      {31'd0, ov0}, {31'd0, m_ov[0]});
    chk("out_taken0",      {31'd0, ot0}, {31'd0, m_ot[0]});
    chk("out_link0",       {31'd0, ol0}, {31'd0, m_ol[0]});
    chk("out_mispredict0", {31'd0, om0}, {31'd0, m_om[0]});
    chk("branch_cnt0",     {16'd0, bc0}, m_bc[0]);
    chk("mispred_cnt0",    {16'd0, mc0}, m_mc[0]);
    chk("out_valid1",      {31'd0, ov1}, {31'd0, m_ov[1]});
    chk("out_taken1",      {31'd0, ot1}, {31'd0, m_ot[1]});
    chk("out_link1",       {31'd0, ol1}, {31'd0, m_ol[1]});
    chk("out_mispredict1", {31'd0, om1}, {31'd0, m_om[1]});
    chk("branch_cnt1",     {28'd0, bc1}, m_bc[1]);
    chk("mispred_cnt1",    {28'd0, mc1}, m_mc[1]);
  endtask

  task automatic br(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] pc, input logic pr);
    res_valid = 1'b1; res_op = op; res_rt = rt; res_a = a; res_b = b;
    res_pc = pc; res_pred = pr; pred_pc = pc;
    step();
  endtask

  task automatic idle(input logic [31:0] pc);
    res_valid = 1'b0; pred_pc = pc;
    step();
  endtask

  initial begin
    logic [5:0]  ops [11] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd1, 6'd0, 6'd2, 6'd8, 6'd35};
    logic [4:0]  rts [5]  = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd3};
    logic [31:0] avs [6]  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_8000, 32'h7FFF_FFFF};

    // Reset while a request is present and stall is high: reset must win.
    resetn = 1'b0; stall = 1'b1; res_valid = 1'b1; res_op = 6'd4; res_rt = 5'd0;
    res_a = 32'h1234; res_b = 32'h1234; res_pc = 32'h0040_0010; res_pred = 1'b0;
    pred_pc = 32'h0040_0010;
    @(posedge clk);
    model_edge();
    step();
    chk("reset_branch_cnt", {16'd0, bc0}, 32'd0);
    resetn = 1'b1; stall = 1'b0;

    // Every index predicts not-taken after reset.
    for (int i = 0; i < 64; i++) idle(32'h0040_0000 + (i << 2));

    // beq taken against a not-taken prediction at index 4.
    br(6'd4, 5'd0, 32'h1234, 32'h1234, 32'h0040_0010, 1'b0);
    chk("beq_taken", {31'd0, ot0}, 32'd1);
    chk("beq_mispred_cnt", {16'd0, mc0}, 32'd1);
    idle(32'h0040_0010);
    chk("beq_pred_now_taken", {31'd0, pt0}, 32'd1);

    // Condition corners.
    br(6'd1, 5'd16, 32'h0000_0005, 32'h0, 32'h0040_0020, 1'b0);   // bltzal
    chk("bltzal_link", {31'd0, ol0}, 32'd1);
    br(6'd7, 5'd0, 32'h0, 32'h0, 32'h0040_0024, 1'b1);            // bgtz 0
    br(6'd6, 5'd0, 32'h8000_0000, 32'h0, 32'h0040_0028, 1'b0);    // blez neg
    br(6'd1, 5'd1, 32'h0000_8000, 32'h0, 32'h0040_002C, 1'b1);    // bgez: 32b pos, 16b neg
    chk("bgez16_not_taken", {31'd0, ot1}, 32'd0);
    br(6'd5, 5'd0, 32'h1, 32'h2, 32'h0040_0030, 1'b1);            // bne
    br(6'd1, 5'd2, 32'h0, 32'h0, 32'h0040_0030, 1'b1);            // non-branch REGIMM
    br(6'd35, 5'd0, 32'h0, 32'h0, 32'h0040_0030, 1'b1);           // non-branch op

    // Saturation: five taken, then three not-taken, at one PC.
    for (int i = 0; i < 5; i++) br(6'd4, 5'd0, 32'h7, 32'h7, 32'h0040_0100, 1'b1);
    for (int i = 0; i < 3; i++) br(6'd5, 5'd0, 32'h7, 32'h7, 32'h0040_0100, 1'b0);
    idle(32'h0040_0100);

    // Stall holds everything; release resolves normally.
    stall = 1'b1;
    br(6'd4, 5'd0, 32'h5, 32'h5, 32'h0040_0200, 1'b0);
    br(6'd4, 5'd0, 32'h5, 32'h5, 32'h0040_0200, 1'b0);
    stall = 1'b0;
    br(6'd4, 5'd0, 32'h5, 32'h5, 32'h0040_0200, 1'b0);

    // Twenty resolves: the 4-bit counter sticks at 15.
    for (int i = 0; i < 20; i++) br(6'd4, 5'd0, 32'h9, 32'h9, 32'h0040_0300 + (i << 2), i[0]);
    chk("branch_cnt_sat", {28'd0, bc1}, 32'd15);

    // Reset mid-stream.
    resetn = 1'b0;
    br(6'd4, 5'd0, 32'h9, 32'h9, 32'h0040_0010, 1'b0);
    chk("midreset_branch_cnt", {28'd0, bc1}, 32'd0);
    resetn = 1'b1;

    // Randomized traffic with index collisions, stalls and occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b, pc;
      a  = ($urandom_range(0, 2) == 0) ? $urandom() : avs[$urandom_range(0, 5)];
      b  = ($urandom_range(0, 1) == 0) ? a : $urandom();
      pc = 32'h0040_0000 + ($urandom_range(0, 31) << 2);
      stall  = ($urandom_range(0, 9) == 0);
      resetn = ($urandom_range(0, 59) != 0);
      res_valid = ($urandom_range(0, 4) != 0);
      res_op = ops[$urandom_range(0, 10)];
      res_rt = ($urandom_range(0, 7) == 0) ? 5'($urandom()) : rts[$urandom_range(0, 4)];
      res_a = a; res_b = b; res_pc = pc; res_pred = 1'($urandom());
      pred_pc = ($urandom_range(0, 1) == 0) ? pc : 32'h0040_0000 + ($urandom_range(0, 31) << 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
